tlast_check: RTL and testbench
==============================

Name: tlast_check

Overview:
AXI4-Stream packet-framing checker and corrector for the receive end of a tlast-framed stream. It consumes packets delimited by s_axis_tlast and compares each packet's beat count against the configured pkt_length. It re-emits every packet on the master side at exactly pkt_length beats: short packets are zero-padded, long packets are truncated and their excess beats are dropped. Framing errors are reported as pulses and as saturating counters. It sits between a packet source (DMA or a tlast generator) and a consumer that requires fixed-length frames.

Parameters:
TDATA_WIDTH, 16, data width in bits.
MAX_PKT_LENGTH, 512, maximum supported packet length in beats.
STAT_W, 16, width of the error counters.

Ports:
aclk  input  1  clock.
resetn  input  1  reset; synchronous, active-low.
pkt_length  input  $clog2(MAX_PKT_LENGTH)+1  expected beats per packet. Valid range is 1..MAX_PKT_LENGTH; 0 is treated as 1.
clear_cnt  input  1  synchronous clear of short_cnt and long_cnt.
s_axis_tvalid  input  1  slave valid.
s_axis_tready  output  1  slave ready.
s_axis_tdata  input  TDATA_WIDTH  slave data.
s_axis_tlast  input  1  slave end of packet.
m_axis_tvalid  output  1  master valid.
m_axis_tready  input  1  master ready.
m_axis_tdata  output  TDATA_WIDTH  master data.
m_axis_tlast  output  1  master end of packet, asserted at beat pkt_length.
pkt_done  output  1  1-cycle pulse when an output tlast beat is accepted.
err_short  output  1  1-cycle pulse on acceptance of an early input tlast.
err_long  output  1  1-cycle pulse on acceptance of a forced output tlast beat that has no input tlast.
len_measured  output  $clog2(MAX_PKT_LENGTH)+1  input beat count of the last completed input packet; saturates at all-ones.
short_cnt  output  STAT_W  saturating count of short packets.
long_cnt  output  STAT_W  saturating count of long packets.

Behaviour:
- Reset (resetn=0 at a rising edge of aclk):
  - state=PASS; out_cnt=0; in_cnt=0; len_q=0.
  - pkt_done, err_short, err_long = 0; len_measured=0; short_cnt=0; long_cnt=0.
  - While resetn=0, s_axis_tready=0 and m_axis_tvalid=0.
  - Reset mid-packet abandons the packet; no tlast is emitted for it.
- Length latch:
  - On the first accepted beat of a packet (PASS, out_cnt==0), len_q <= max(pkt_length,1).
  - The effective length for that beat is max(pkt_length,1). len_q is used for the rest of the packet.
  - Changes to pkt_length mid-packet do not affect the current packet.
- Output tlast: lastbeat = (out_cnt == effective length - 1).
- PASS state, zero latency, combinational pass-through:
  - m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tdata=s_axis_tdata, m_axis_tlast=lastbeat.
  - beat = s_axis_tvalid & m_axis_tready.
  - beat & lastbeat & s_tlast: out_cnt<=0, in_cnt<=0, pkt_done=1, len_measured<=in_cnt+1.
  - beat & lastbeat & ~s_tlast: out_cnt<=0, in_cnt<=in_cnt+1, pkt_done=1, err_long=1, go DROP.
  - beat & ~lastbeat & s_tlast: the beat is forwarded with m_tlast=0. out_cnt<=out_cnt+1, in_cnt<=0, len_measured<=in_cnt+1, err_short=1, go PAD.
  - beat & ~lastbeat & ~s_tlast: out_cnt++, in_cnt++.
- PAD state:
  - s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=0, m_axis_tlast=lastbeat (against len_q).
  - On m_axis_tready: if lastbeat, out_cnt<=0, pkt_done=1, go PASS; else out_cnt++.
- DROP state:
  - s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0.
  - Each accepted beat increments in_cnt (saturating).
  - Accepted beat with s_tlast: len_measured<=in_cnt+1, in_cnt<=0, go PASS. The next beat starts a new packet.
- Counters:
  - short_cnt increments on err_short; long_cnt increments on err_long. Both saturate at 2^STAT_W-1.
  - clear_cnt wins over a simultaneous increment.
- AXIS rules:
  - m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 & m_axis_tready=0. In PASS this relies on the source obeying AXIS.
  - No beat is lost or duplicated except beats dropped in DROP.
- Width:
  - in_cnt and len_measured are $clog2(MAX_PKT_LENGTH)+1 bits and saturate.
  - out_cnt never exceeds len_q-1.

Test Plan:
- pkt_length=4, m_tready=1, three 4-beat packets with tlast on beat 4 -> m_tlast on output beats 4, 8, 12; 3 pkt_done pulses; no err pulses; len_measured=4; counters remain 0.
- pkt_length=8, 5-beat packet D1..D5 with tlast on D5 -> D1..D5 output with m_tlast=0, then 3 beats of 0x0000 with m_tlast on the 3rd; s_tready=0 during the 3 pad beats; err_short=1 once; short_cnt=1; len_measured=5.
- pkt_length=4, 7-beat packet, then a 4-beat packet -> beats 1-4 output with m_tlast on beat 4 and err_long pulsed; beats 5-7 accepted and dropped with m_tvalid=0; long_cnt=1; len_measured=7; following packet passes cleanly.
- pkt_length=6, random 50% m_tready and s_tvalid over 200 packets of mixed lengths 1..10 -> scoreboard sees every output packet at exactly 6 beats with correct data order and zero padding; short_cnt and long_cnt match the model.
- pkt_length changed from 4 to 6 after beat 2 of a packet -> that packet ends at beat 4; the next packet ends at beat 6. pkt_length=0 -> every beat carries m_tlast.
- Assert resetn=0 in the middle of a PAD state; separately, assert clear_cnt in the same cycle as err_long -> after reset, state PASS with s_tready following m_tready and all outputs 0; long_cnt=0 after the clear.

Source files
------------

// File: rtl/tlast_check.sv
// tlast_check: AXI4-Stream framing checker/corrector. Every input packet
// (delimited by s_axis_tlast) is re-emitted at exactly pkt_length beats:
// short packets are zero-padded, long packets are truncated and the excess
// input beats are dropped. Framing errors are reported as one-cycle pulses
// and as saturating counters.
//
// Ports:
//   aclk, resetn          clock; synchronous active-low reset
//   pkt_length            expected beats per packet (0 treated as 1)
//   clear_cnt             synchronous clear of short_cnt / long_cnt
//   s_axis_*              slave stream (tvalid, tready, tdata, tlast)
//   m_axis_*              master stream (tvalid, tready, tdata, tlast)
//   pkt_done              pulse after an output tlast beat is accepted
//   err_short             pulse after an early input tlast is accepted
//   err_long              pulse after a forced output tlast is accepted
//   len_measured          beat count of the last completed input packet
//   short_cnt, long_cnt   saturating error counters
module tlast_check #(
  parameter int unsigned TDATA_WIDTH    = 16,
  parameter int unsigned MAX_PKT_LENGTH = 512,
  parameter int unsigned STAT_W         = 16
) (
  input  logic                              aclk,
  input  logic                              resetn,
  input  logic [$clog2(MAX_PKT_LENGTH):0]   pkt_length,
  input  logic                              clear_cnt,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic                              pkt_done,
  output logic                              err_short,
  output logic                              err_long,
  output logic [$clog2(MAX_PKT_LENGTH):0]   len_measured,
  output logic [STAT_W-1:0]                 short_cnt,
  output logic [STAT_W-1:0]                 long_cnt
);

  localparam int unsigned LW = $clog2(MAX_PKT_LENGTH) + 1;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              r_state;
  logic [LW-1:0]       r_out_cnt;
  logic [LW-1:0]       r_in_cnt;
  logic [LW-1:0]       r_len_q;
  logic [LW-1:0]       r_len_meas;
  logic                r_pkt_done;
  logic                r_err_short;
  logic                r_err_long;
  logic [STAT_W-1:0]   r_short_cnt;
  logic [STAT_W-1:0]   r_long_cnt;

  logic                w_first;
  logic [LW-1:0]       w_pkt_len_eff;
  logic [LW-1:0]       w_len_eff;
  logic                w_lastbeat;
  logic [LW-1:0]       w_in_cnt_inc;
  logic                w_pass_beat;
  logic                w_pad_beat;
  logic                w_drop_beat;
  logic                w_short_evt;
  logic                w_long_evt;

  // Effective length: the live pkt_length on the first beat of a packet,
  // the latched copy for every later beat.
  always_comb begin
    w_first       = (r_state == ST_PASS) && (r_out_cnt == '0);
    w_pkt_len_eff = (pkt_length == '0) ? LW'(1) : pkt_length;
    w_len_eff     = w_first ? w_pkt_len_eff : r_len_q;
    w_lastbeat    = (r_out_cnt == (w_len_eff - LW'(1)));
    w_in_cnt_inc  = (r_in_cnt == '1) ? r_in_cnt : (r_in_cnt + LW'(1));

    w_pass_beat   = resetn && (r_state == ST_PASS) && s_axis_tvalid && m_axis_tready;
    w_pad_beat    = resetn && (r_state == ST_PAD) && m_axis_tready;
    w_drop_beat   = resetn && (r_state == ST_DROP) && s_axis_tvalid;
    w_short_evt   = w_pass_beat && !w_lastbeat && s_axis_tlast;
    w_long_evt    = w_pass_beat && w_lastbeat && !s_axis_tlast;
  end

  // Stream outputs: zero-latency pass-through in PASS, zero beats in PAD,
  // sink-only in DROP; everything held quiet while in reset.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (resetn) begin
      case (r_state)
        ST_PASS: begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tlast  = w_lastbeat;
        end
        ST_PAD: begin
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = w_lastbeat;
        end
        ST_DROP: begin
          s_axis_tready = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Framing state machine, beat counters and status pulses.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state     <= ST_PASS;
      r_out_cnt   <= '0;
      r_in_cnt    <= '0;
      r_len_q     <= '0;
      r_len_meas  <= '0;
      r_pkt_done  <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_pkt_done  <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      case (r_state)
        ST_PASS: begin
          if (w_pass_beat) begin
            if (w_first) begin
              r_len_q <= w_pkt_len_eff;
            end
            if (w_lastbeat && s_axis_tlast) begin
              r_out_cnt  <= '0;
              r_in_cnt   <= '0;
              r_pkt_done <= 1'b1;
              r_len_meas <= w_in_cnt_inc;
            end else if (w_lastbeat) begin
              // Output frame is full but input keeps going: drop the rest.
              r_out_cnt  <= '0;
              r_in_cnt   <= w_in_cnt_inc;
              r_pkt_done <= 1'b1;
              r_err_long <= 1'b1;
              r_state    <= ST_DROP;
            end else if (s_axis_tlast) begin
              // Input ended early: pad the output frame with zero beats.
              r_out_cnt   <= r_out_cnt + LW'(1);
              r_in_cnt    <= '0;
              r_len_meas  <= w_in_cnt_inc;
              r_err_short <= 1'b1;
              r_state     <= ST_PAD;
            end else begin
              r_out_cnt <= r_out_cnt + LW'(1);
              r_in_cnt  <= w_in_cnt_inc;
            end
          end
        end
        ST_PAD: begin
          if (w_pad_beat) begin
            if (w_lastbeat) begin
              r_out_cnt  <= '0;
              r_pkt_done <= 1'b1;
              r_state    <= ST_PASS;
            end else begin
              r_out_cnt <= r_out_cnt + LW'(1);
            end
          end
        end
        ST_DROP: begin
          if (w_drop_beat) begin
            if (s_axis_tlast) begin
              r_len_meas <= w_in_cnt_inc;
              r_in_cnt   <= '0;
              r_state    <= ST_PASS;
            end else begin
              r_in_cnt <= w_in_cnt_inc;
            end
          end
        end
        default: begin
          r_state <= ST_PASS;
        end
      endcase
    end
  end

  // Saturating error counters; a clear takes precedence over an increment.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_short_cnt <= '0;
      r_long_cnt  <= '0;
    end else if (clear_cnt) begin
      r_short_cnt <= '0;
      r_long_cnt  <= '0;
    end else begin
      if (w_short_evt && (r_short_cnt != '1)) begin
        r_short_cnt <= r_short_cnt + STAT_W'(1);
      end
      if (w_long_evt && (r_long_cnt != '1)) begin
        r_long_cnt <= r_long_cnt + STAT_W'(1);
      end
    end
  end

  assign pkt_done     = r_pkt_done;
  assign err_short    = r_err_short;
  assign err_long     = r_err_long;
  assign len_measured = r_len_meas;
  assign short_cnt    = r_short_cnt;
  assign long_cnt     = r_long_cnt;

endmodule

// File: tb/tb_tlast_check.sv
// Directed bench for tlast_check: framing pass-through, padding, truncation,
// mid-packet length change, zero length, randomized scoreboard run, reset in
// PAD and clear/increment collision.
module tb_tlast_check;

  logic        aclk;
  logic        resetn;
  logic [9:0]  pkt_length;
  logic        clear_cnt;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        pkt_done;
  logic        err_short;
  logic        err_long;
  logic [9:0]  len_measured;
  logic [15:0] short_cnt;
  logic [15:0] long_cnt;

  logic        rand_rdy;
  logic        rdy;
  logic        rnd_bit;
  logic        rand_gap;

  int n_tests;
  int n_fail;

  // Monitor state (written only by the monitor process)
  logic [16:0] outq[$];
  int m_done, m_short, m_long, m_pad, m_drop;

  // Main-process bookkeeping
  logic [16:0] exp_q[$];
  int rd;
  int b_done, b_short, b_long, b_pad, b_drop;

  tlast_check dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .pkt_length    (pkt_length),
    .clear_cnt     (clear_cnt),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .pkt_done      (pkt_done),
    .err_short     (err_short),
    .err_long      (err_long),
    .len_measured  (len_measured),
    .short_cnt     (short_cnt),
    .long_cnt      (long_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  assign m_tready = rand_rdy ? rnd_bit : rdy;

  always @(negedge aclk) begin
    if (m_tvalid && m_tready) outq.push_back({m_tlast, m_tdata});
    if (pkt_done)  m_done++;
    if (err_short) m_short++;
    if (err_long)  m_long++;
    if (m_tvalid && m_tready && !s_tready) m_pad++;
    if (s_tvalid && s_tready && !m_tvalid) m_drop++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_done = m_done; b_short = m_short; b_long = m_long;
    b_pad = m_pad; b_drop = m_drop;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int t;
    logic acc;
    if (rand_gap && ($urandom_range(0, 1) == 1)) begin
      @(posedge aclk); #1;
    end
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    acc = 1'b0; t = 0;
    while (!acc && t < 2000) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk); #1;
      t++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [15:0] base);
    for (int k = 0; k < len; k++) send_beat(base + 16'(k), (k == len - 1));
  endtask

  // Wait for n new output beats beyond rd, then let pulses settle.
  task automatic wait_out(input int n);
    int t;
    t = 0;
    while ((outq.size() - rd) < n && t < 20000) begin
      @(negedge aclk);
      t++;
    end
    if ((outq.size() - rd) < n) chk("out_timeout", 32'(outq.size() - rd), 32'(n));
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1;
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd + i < outq.size()) chk(tag, 32'(outq[rd + i]), 32'(exp_q[i]));
      else chk({tag, "_missing"}, 32'(i), 32'(exp_q.size()));
    end
    chk({tag, "_extra"}, 32'(outq.size() - rd), 32'(exp_q.size()));
    rd = outq.size();
    exp_q.delete();
  endtask

  int exp_short, exp_long, plen, last_len;
  logic [15:0] pd[16];

  initial begin
    n_tests = 0; n_fail = 0; rd = 0;
    resetn = 1'b0; pkt_length = 10'd4; clear_cnt = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    rand_rdy = 1'b0; rdy = 1'b1; rand_gap = 1'b0;
    repeat (3) @(posedge aclk); #1;

    // Reset state
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_pulses", {29'd0, pkt_done, err_short, err_long}, 32'd0);
    chk("rst_len", 32'(len_measured), 32'd0);
    chk("rst_cnts", {short_cnt, long_cnt}, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_pass_ready", 32'(s_tready), 32'd1);
    rd = outq.size();

    // S1: three exact 4-beat packets
    snap();
    for (int p = 0; p < 3; p++) send_pkt(4, 16'(p * 4 + 1));
    for (int i = 0; i < 12; i++) exp_q.push_back({(i % 4 == 3), 16'(i + 1)});
    wait_out(12);
    check_out("s1_beat");
    chk("s1_done", 32'(m_done - b_done), 32'd3);
    chk("s1_errs", 32'((m_short - b_short) + (m_long - b_long)), 32'd0);
    chk("s1_len", 32'(len_measured), 32'd4);
    chk("s1_cnts", {short_cnt, long_cnt}, 32'd0);

    // S2: 5-beat packet against length 8 -> three zero pad beats
    pkt_length = 10'd8; snap();
    send_pkt(5, 16'h00D1);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 16'h00D1 + 16'(i)});
    exp_q.push_back(17'h0_0000); exp_q.push_back(17'h0_0000); exp_q.push_back(17'h1_0000);
    wait_out(8);
    check_out("s2_beat");
    chk("s2_pad_cycles", 32'(m_pad - b_pad), 32'd3);
    chk("s2_err_short", 32'(m_short - b_short), 32'd1);
    chk("s2_short_cnt", 32'(short_cnt), 32'd1);
    chk("s2_len", 32'(len_measured), 32'd5);
    chk("s2_done", 32'(m_done - b_done), 32'd1);

    // S3: 7-beat packet against length 4, then a clean 4-beat packet
    pkt_length = 10'd4; snap();
    send_pkt(7, 16'h0031);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 16'h0031 + 16'(i)});
    wait_out(4);
    check_out("s3_trunc");
    chk("s3_err_long", 32'(m_long - b_long), 32'd1);
    chk("s3_drop", 32'(m_drop - b_drop), 32'd3);
    chk("s3_long_cnt", 32'(long_cnt), 32'd1);
    chk("s3_len7", 32'(len_measured), 32'd7);
    send_pkt(4, 16'h0041);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 16'h0041 + 16'(i)});
    wait_out(4);
    check_out("s3_next");
    chk("s3_len4", 32'(len_measured), 32'd4);
    chk("s3_no_more_err", 32'(m_long - b_long), 32'd1);

    // S4: pkt_length 4 -> 6 after beat 2; then pkt_length 0
    snap();
    send_beat(16'h0051, 1'b0); send_beat(16'h0052, 1'b0);
    pkt_length = 10'd6;
    send_beat(16'h0053, 1'b0); send_beat(16'h0054, 1'b1);
    send_pkt(6, 16'h0061);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 16'h0051 + 16'(i)});
    for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5), 16'h0061 + 16'(i)});
    wait_out(10);
    check_out("s4_chg");
    chk("s4_errs", 32'((m_short - b_short) + (m_long - b_long)), 32'd0);
    pkt_length = 10'd0; snap();
    for (int i = 0; i < 3; i++) send_pkt(1, 16'h0071 + 16'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 16'h0071 + 16'(i)});
    wait_out(3);
    check_out("s4_zero");
    chk("s4_zero_done", 32'(m_done - b_done), 32'd3);
    chk("s4_zero_len", 32'(len_measured), 32'd1);

    // S5: randomized handshakes, 200 packets of length 1..10 against 6
    pkt_length = 10'd6; rand_rdy = 1'b1; rand_gap = 1'b1; snap();
    exp_short = 1; exp_long = 1; last_len = 0;
    for (int p = 0; p < 200; p++) begin
      plen = $urandom_range(1, 10);
      for (int k = 0; k < plen; k++) pd[k] = 16'($urandom);
      for (int k = 0; k < 6; k++) exp_q.push_back({(k == 5), (k < plen) ? pd[k] : 16'h0000});
      if (plen < 6) exp_short++;
      if (plen > 6) exp_long++;
      for (int k = 0; k < plen; k++) send_beat(pd[k], (k == plen - 1));
      last_len = plen;
    end
    wait_out(1200);
    rand_rdy = 1'b0; rand_gap = 1'b0;
    repeat (4) @(posedge aclk); #1;
    check_out("s5_sb");
    chk("s5_done", 32'(m_done - b_done), 32'd200);
    chk("s5_short_cnt", 32'(short_cnt), 32'(exp_short));
    chk("s5_long_cnt", 32'(long_cnt), 32'(exp_long));
    chk("s5_len", 32'(len_measured), 32'(last_len));

    // S6: reset while stalled in PAD
    pkt_length = 10'd8;
    send_pkt(2, 16'h0081);
    rdy = 1'b0; #1;
    chk("s6_in_pad", {29'd0, m_tvalid, s_tready, 1'b0}, 32'h4);
    resetn = 1'b0;
    @(posedge aclk); #1;
    chk("s6_rst_outs", {30'd0, m_tvalid, s_tready}, 32'd0);
    @(posedge aclk); #1;
    resetn = 1'b1; #1;
    rd = outq.size();
    chk("s6_after_tvalid", 32'(m_tvalid), 32'd0);
    chk("s6_after_ready0", 32'(s_tready), 32'(m_tready));
    rdy = 1'b1; #1;
    chk("s6_after_ready1", 32'(s_tready), 32'(m_tready));
    chk("s6_after_stats", {len_measured, 3'b000, pkt_done, err_short, err_long}, 32'd0);
    chk("s6_after_cnts", {short_cnt, long_cnt}, 32'd0);
    send_pkt(8, 16'h0091);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 16'h0091 + 16'(i)});
    wait_out(8);
    check_out("s6_fresh");

    // S7: clear_cnt coincides with err_long
    pkt_length = 10'd1; snap();
    clear_cnt = 1'b1;
    send_beat(16'h00A1, 1'b0);
    clear_cnt = 1'b0;
    send_beat(16'h00A2, 1'b1);
    repeat (2) @(posedge aclk); #1;
    chk("s7_err_long", 32'(m_long - b_long), 32'd1);
    chk("s7_cleared", 32'(long_cnt), 32'd0);
    send_pkt(2, 16'h00B1);
    repeat (2) @(posedge aclk); #1;
    chk("s7_incr", 32'(long_cnt), 32'd1);
    chk("s7_len", 32'(len_measured), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
